// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 demux and its upstream feeder.
// Holds channel geometry, FSM state encoding and the drop counter ceiling.
package demux_pkg;
   localparam int SEL_W   = 2;
   localparam int NUM_CH  = 4;
   localparam int ENTRY_W = SEL_W + 1;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_HOLD = 1'b1;

   localparam logic [7:0] DROP_MAX = 8'd255;

   typedef enum logic {
      S_IDLE = ST_IDLE,
      S_HOLD = ST_HOLD
   } state_t;

   typedef struct packed {
      logic [SEL_W-1:0] dest;
      logic             data;
   } entry_t;
endpackage

// File: rtl/demux_feeder_fifo.sv
// Synchronous DEPTH x {dest,data} queue with flush; head is read combinationally.
// Pushes into a full queue and pops from an empty queue are ignored.
module demux_feeder_fifo
   import demux_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  entry_t                 wdata,
   output entry_t                 rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PTR_W = $clog2(DEPTH);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst && !flush && do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers are exactly log2(DEPTH) bits so they wrap without extra logic.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/demux_feeder.sv
// Feeder for the 1-to-4 demux: queues routed bits, presents each for HOLD cycles,
// and discards requests aimed at disabled channels while counting them.
module demux_feeder
   import demux_pkg::*;
#(
   parameter int               DEPTH    = 4,
   parameter int               HOLD     = 2,
   parameter logic [SEL_W-1:0] IDLE_SEL = 2'b00
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SEL_W-1:0]       in_dest,
   input  logic                   in_data,
   input  logic [NUM_CH-1:0]      ch_mask,
   input  logic                   flush,
   output logic                   din,
   output logic [SEL_W-1:0]       sel,
   output logic                   dout_valid,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [7:0]             drop_cnt,
   output logic                   fsm_state
);
   localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;

   // Handshake: a request transfers on a rising edge where in_valid && in_ready;
   // in_ready depends only on queue fullness and reset, never on in_valid.
   state_t    state;
   logic [HC_W-1:0] hold_cnt;
   entry_t    head;
   entry_t    wdata;
   logic      full;
   logic      empty;
   logic      accept;
   logic      keep;
   logic      push;
   logic      pop;

   assign in_ready  = !full && !rst;
   assign accept    = in_valid && in_ready;
   assign keep      = ch_mask[in_dest];
   assign push      = accept && keep && !flush;
   assign pop       = !flush && !empty &&
                      ((state == S_IDLE) || (hold_cnt == '0));
   assign wdata     = '{dest: in_dest, data: in_data};
   assign busy      = (state == S_HOLD) || (fifo_count != '0);
   assign fsm_state = state;

   demux_feeder_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (wdata),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   // A pop reloads the hold counter, so consecutive entries follow with no idle gap.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state      <= S_IDLE;
         din        <= 1'b0;
         sel        <= IDLE_SEL;
         dout_valid <= 1'b0;
         hold_cnt   <= '0;
      end else if (pop) begin
         state      <= S_HOLD;
         din        <= head.data;
         sel        <= head.dest;
         dout_valid <= 1'b1;
         hold_cnt   <= HC_W'(HOLD - 1);
      end else if (state == S_HOLD) begin
         if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
         end else begin
            state      <= S_IDLE;
            din        <= 1'b0;
            sel        <= IDLE_SEL;
            dout_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (accept && !keep && !flush && (drop_cnt != DROP_MAX)) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_demux_feeder.sv
// Directed bench for demux_feeder (DEPTH=4, HOLD=2, IDLE_SEL=00).
// Outputs are sampled 1ns after each rising edge; inputs change at the same point.
module tb_demux_feeder;
   import demux_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [1:0] in_dest = 2'd0;
   logic       in_data = 1'b0;
   logic [3:0] ch_mask = 4'b1111;
   logic       flush = 1'b0;
   logic       din;
   logic [1:0] sel;
   logic       dout_valid;
   logic       busy;
   logic [2:0] fifo_count;
   logic [7:0] drop_cnt;
   logic       fsm_state;

   int n_vec = 0;
   int n_err = 0;
   logic [2:0] exp_q[$];

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   demux_feeder #(.DEPTH(4), .HOLD(2), .IDLE_SEL(2'b00)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_dest    (in_dest),
      .in_data    (in_data),
      .ch_mask    (ch_mask),
      .flush      (flush),
      .din        (din),
      .sel        (sel),
      .dout_valid (dout_valid),
      .busy       (busy),
      .fifo_count (fifo_count),
      .drop_cnt   (drop_cnt),
      .fsm_state  (fsm_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [1:0] dest, input logic data);
      in_valid = 1'b1;
      in_dest  = dest;
      in_data  = data;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_dv"},  dout_valid, 0);
      check({tag, "_sel"}, sel, 2'b00);
      check({tag, "_din"}, din, 0);
   endtask

   logic [2:0] vecs [8] = '{3'b001, 3'b010, 3'b101, 3'b110,
                            3'b111, 3'b000, 3'b011, 3'b100};

   initial begin
      int idx;
      int run;
      int max_cnt;
      logic acc;

      // reset then idle
      tick();
      tick();
      check_idle("rst");
      check("rst_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_cnt", fifo_count, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_state", fsm_state, ST_IDLE);
      rst = 1'b0;
      #1;
      check("rel_ready", in_ready, 1);
      check("rel_cnt", fifo_count, 0);

      // single entry, dest=2 data=1
      push_one(2'd2, 1'b1);
      check("single_queued", fifo_count, 1);
      check("single_nobypass", dout_valid, 0);
      for (int k = 0; k < 2; k++) begin
         tick();
         check("single_dv", dout_valid, 1);
         check("single_sel", sel, 2'b10);
         check("single_din", din, 1);
      end
      tick();
      check_idle("single_end");
      check("single_busy", busy, 0);

      // back-to-back dest 0..3, each held 2 cycles with no gap
      in_valid = 1'b1;
      in_dest  = 2'd0;
      in_data  = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) begin
         if (k < 3) begin
            in_dest = 2'(k + 1);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         check("b2b_dv", dout_valid, 1);
         check("b2b_sel", sel, k / 2);
         check("b2b_din", din, 1);
         if (k == 0) check("b2b_pushpop_cnt", fifo_count, 1);
      end
      tick();
      check_idle("b2b_end");

      // backpressure: push faster than drain, scoreboard the order
      idx = 0;
      run = 0;
      max_cnt = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (idx == 8 && exp_q.size() == 0 && !dout_valid && cyc > 0) break;
         if (idx < 8) begin
            in_valid = 1'b1;
            {in_dest, in_data} = vecs[idx];
         end else begin
            in_valid = 1'b0;
         end
         acc = in_valid && in_ready;
         check("bp_ready", in_ready, fifo_count != 3'd4);
         tick();
         if (acc) begin
            exp_q.push_back(vecs[idx]);
            idx++;
         end
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
         if (dout_valid) begin
            run++;
            if (run % 2 == 1) begin
               if (exp_q.size() == 0) begin
                  check("bp_extra", {sel, din}, 3'b000);
                  check("bp_extra_entry", 1, 0);
               end else begin
                  check("bp_order", {sel, din}, exp_q.pop_front());
               end
            end
         end else begin
            run = 0;
         end
      end
      in_valid = 1'b0;
      check("bp_all_accepted", idx, 8);
      check("bp_all_presented", exp_q.size(), 0);
      check("bp_reached_full", max_cnt, 4);

      // mask filter
      ch_mask = 4'b1011;
      push_one(2'd2, 1'b1);
      check("mask_drop", drop_cnt, 1);
      check("mask_cnt", fifo_count, 0);
      tick();
      check_idle("mask_notshown");

      // mask sampled only at accept
      push_one(2'd0, 1'b1);
      ch_mask = 4'b0000;
      tick();
      check("mask_late_dv", dout_valid, 1);
      check("mask_late_sel", sel, 2'b00);
      check("mask_late_din", din, 1);
      tick();
      tick();
      check_idle("mask_late_end");

      // flush mid-HOLD, with a same-cycle masked accept that must not count
      ch_mask = 4'b1111;
      push_one(2'd1, 1'b0);
      push_one(2'd2, 1'b1);
      push_one(2'd3, 1'b0);
      check("flush_pre_dv", dout_valid, 1);
      check("flush_pre_sel", sel, 2'b01);
      check("flush_pre_cnt", fifo_count, 2);
      flush    = 1'b1;
      ch_mask  = 4'b0111;
      in_valid = 1'b1;
      in_dest  = 2'd3;
      in_data  = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      ch_mask  = 4'b1111;
      check_idle("flush");
      check("flush_cnt", fifo_count, 0);
      check("flush_drop", drop_cnt, 1);
      check("flush_busy", busy, 0);
      tick();
      check_idle("flush_after");

      // drop counter saturation
      ch_mask  = 4'b0000;
      in_valid = 1'b1;
      in_dest  = 2'd1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (i == 252) check("sat_254", drop_cnt, 254);
      end
      in_valid = 1'b0;
      check("sat_255", drop_cnt, 255);
      check("sat_cnt", fifo_count, 0);

      // reset mid-HOLD
      ch_mask = 4'b1111;
      push_one(2'd1, 1'b1);
      push_one(2'd2, 1'b1);
      push_one(2'd3, 1'b1);
      check("rst_mid_pre_dv", dout_valid, 1);
      rst = 1'b1;
      tick();
      check_idle("rst_mid");
      check("rst_mid_cnt", fifo_count, 0);
      check("rst_mid_drop", drop_cnt, 0);
      check("rst_mid_ready", in_ready, 0);
      check("rst_mid_state", fsm_state, ST_IDLE);
      rst = 1'b0;
      #1;
      check("rst_mid_rel_ready", in_ready, 1);
      tick();
      check_idle("rst_mid_after");
      check("rst_mid_after_busy", busy, 0);

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/demux_feeder.md
Name: demux_feeder

Overview:
- Upstream stage for the 1-to-4 demux. It accepts routed single-bit requests {dest, data} over a valid/ready handshake and queues them in a small FIFO.
- It drives the demux's din/sel pair with each entry held stable for HOLD clock cycles, and flags when the presented selection is meaningful.
- It filters requests to disabled channels and counts them as drops.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- HOLD, 2, cycles each entry is presented on din/sel; at least 1.
- IDLE_SEL, 2'b00, sel value driven while nothing is presented.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept; equals !full && !rst.
- in_dest  input  2  target channel 0..3.
- in_data  input  1  bit to route.
- ch_mask  input  4  per-channel enable; bit n=1 enables channel n.
- flush  input  1  synchronous queue clear.
- din  output  1  to demux din.
- sel  output  2  to demux sel.
- dout_valid  output  1  din/sel hold a real entry this cycle.
- busy  output  1  FSM in HOLD or FIFO non-empty.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  output  8  masked requests discarded; saturates.

Behaviour:
- Reset values (all outputs and state, applied at the first rising edge with rst=1):
  - din=0, sel=IDLE_SEL, dout_valid=0, busy=0, fifo_count=0, drop_cnt=0.
  - FSM goes to IDLE; FIFO pointers go to 0.
  - in_ready=0 while rst is high.
- Reset mid-HOLD aborts the entry immediately and discards queued entries.
- Accept occurs on a rising edge with in_valid && in_ready.
  - If ch_mask[in_dest]=1, the pair is written to the FIFO tail.
  - If ch_mask[in_dest]=0, the pair is consumed but not stored; drop_cnt increments, saturating at 255.
  - The mask is sampled only at accept. Later mask changes do not affect queued entries.
- in_ready depends on full only. When full, no push happens even if a pop occurs in the same cycle.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - din=0, sel=IDLE_SEL, dout_valid=0.
  - If the FIFO is non-empty, pop the head, register din/sel from it, load hold_cnt=HOLD-1, set dout_valid=1, and go to HOLD.
- HOLD:
  - din, sel and dout_valid=1 stay constant.
  - If hold_cnt>0, decrement it.
  - If hold_cnt==0 and the FIFO is non-empty, pop the next entry back-to-back with no idle gap and reload hold_cnt.
  - If hold_cnt==0 and the FIFO is empty, return to IDLE values at that edge.
- Latency:
  - An entry accepted at edge t into an idle, empty block appears on din/sel at edge t+1.
  - No same-edge bypass.
- Simultaneous push and pop (not full): fifo_count is unchanged; both take effect.
- An entry pushed at the same edge the FIFO goes empty is not visible to that edge's pop decision. It is popped at the next edge.
- flush (when rst=0):
  - Clears FIFO pointers and count, forces IDLE outputs next edge, aborts the current HOLD.
  - drop_cnt is untouched.
  - Any accept in the same cycle is discarded and is not counted as a drop.
- rst has priority over flush. flush has priority over push/pop.
- Pointers are log2(DEPTH) bits and wrap naturally. fifo_count is one bit wider so full (count==DEPTH) and empty (count==0) are distinct.
- busy = (state==HOLD) || (fifo_count!=0).

Decomposition:
- Shared package demux_pkg holds:
  - SEL_W=2 and NUM_CH=4;
  - state encoding localparams ST_IDLE/ST_HOLD;
  - the DROP_MAX=255 constant.
  The demux itself takes the same SEL_W/NUM_CH.
- One natural sub-module: demux_feeder_fifo, a synchronous DEPTH x 3-bit FIFO with push, pop, flush, full, empty and count.
- The FSM, hold counter, mask filter and drop counter stay in the top.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → din=0, sel=00, dout_valid=0, in_ready=0. After release, in_ready=1 and fifo_count=0.
- Single entry, HOLD=2, mask=1111: accept {dest=2, data=1} at edge t → sel=10, din=1, dout_valid=1 at edges t+1 and t+2; IDLE values at t+3.
- Back-to-back: push dest 0,1,2,3 (data=1) on consecutive cycles → sel steps 00,01,10,11, each held exactly 2 cycles, dout_valid continuously 1 for 8 cycles.
- Full/backpressure, DEPTH=4, output stalled in HOLD:
  - 5 pushes while the first is in HOLD → in_ready=0 when fifo_count=4;
  - no entry lost or duplicated, order preserved.
- Mask and saturation:
  - ch_mask=1011, push dest=2 → not presented, drop_cnt=1.
  - 300 masked pushes → drop_cnt=255.
- Flush/reset mid-HOLD: 3 entries queued, assert flush during HOLD → next edge IDLE values, fifo_count=0, drop_cnt unchanged. Repeat with rst → same, plus drop_cnt=0.
